// File: rtl/ram_sync_be_pkg.sv
// ---------------------------------------------------------------------------
// ram_sync_be_pkg
// Shared constants and types for the data RAM slice (ram_sync_be and its
// read pipeline). No ports; imported with `import ram_sync_be_pkg::*;`.
//   BYTE_WIDTH         width of one write-strobe lane
//   RAM_RD_LAT_DEFAULT default read latency in cycles
//   WRITE_ENABLE       value of req_we_i that selects a write
//   ram_state_e        zero-fill / ready controller states
// ---------------------------------------------------------------------------
package ram_sync_be_pkg;

  localparam int   BYTE_WIDTH         = 8;
  localparam int   RAM_RD_LAT_DEFAULT = 1;
  localparam logic WRITE_ENABLE       = 1'b1;

  typedef enum logic {
    RAM_ST_INIT  = 1'b0,
    RAM_ST_READY = 1'b1
  } ram_state_e;

endpackage

// File: rtl/ram_sync_be_rd_pipe.sv
// ---------------------------------------------------------------------------
// ram_rd_pipe
// Delay line carrying read-response valid/data (and the access-error flag
// when RAM_ACCESS_ERR_EN is defined) through RD_LATENCY register stages.
// A synchronous flush clears every stage so in-flight responses are dropped.
// Ports:
//   clk_i       clock
//   flush_i     synchronous clear of all stages and of the held data
//   in_valid_i  read accepted this cycle
//   in_data_i   word sampled at the accept edge
//   in_err_i    access error for this slot (RAM_ACCESS_ERR_EN only)
//   out_valid_o one-cycle response pulse
//   out_data_o  response data; holds its value between pulses
//   out_err_o   error pulse aligned with the response slot (RAM_ACCESS_ERR_EN only)
// ---------------------------------------------------------------------------
module ram_rd_pipe
  import ram_sync_be_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = RAM_RD_LAT_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
`ifdef RAM_ACCESS_ERR_EN
  input  logic                  in_err_i,
  output logic                  out_err_o,
`endif
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_data_o
);

  logic [RD_LATENCY-1:0] vld;
  logic [DATA_WIDTH-1:0] dat [RD_LATENCY];

  // Data registers only load when their valid bit moves in, so the last stage
  // keeps presenting the previous response between pulses.
  always_ff @(posedge clk_i) begin
    if (flush_i) begin
      vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) dat[i] <= '0;
    end else begin
      vld[0] <= in_valid_i;
      if (in_valid_i) dat[0] <= in_data_i;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) dat[i] <= dat[i-1];
      end
    end
  end

`ifdef RAM_ACCESS_ERR_EN
  logic [RD_LATENCY-1:0] err;

  // The error flag travels independently of valid because writes flag it too.
  always_ff @(posedge clk_i) begin
    if (flush_i) begin
      err <= '0;
    end else begin
      err[0] <= in_err_i;
      for (int i = 1; i < RD_LATENCY; i++) err[i] <= err[i-1];
    end
  end

  assign out_err_o = err[RD_LATENCY-1];
`endif

  assign out_valid_o = vld[RD_LATENCY-1];
  assign out_data_o  = dat[RD_LATENCY-1];

endmodule

// File: rtl/ram_sync_be.sv
// ---------------------------------------------------------------------------
// ram_sync_be
// Single-port data RAM behind the load/store unit: registered read of 1 or 2
// cycles, byte-lane write strobes, valid/ready requests and a zero-fill sweep
// of every word after reset. Optional macro RAM_ACCESS_ERR_EN adds err_o and
// rejects misaligned or out-of-range accesses.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   req_valid_i    request present;  req_ready_o  low during zero-fill
//   req_we_i       1 = write;        req_be_i     byte-lane write strobes
//   req_addr_i     byte address;     req_wdata_i  write data
//   rsp_valid_o    read data pulse;  rsp_rdata_o  read data (held)
//   init_done_o    zero-fill finished
//   err_o          access error pulse (RAM_ACCESS_ERR_EN only)
// ---------------------------------------------------------------------------
module ram_sync_be
  import ram_sync_be_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4096,
  parameter int RD_LATENCY = RAM_RD_LAT_DEFAULT
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             req_valid_i,
  output logic                             req_ready_o,
  input  logic                             req_we_i,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] req_be_i,
  input  logic [ADDR_WIDTH-1:0]            req_addr_i,
  input  logic [DATA_WIDTH-1:0]            req_wdata_i,
  output logic                             rsp_valid_o,
  output logic [DATA_WIDTH-1:0]            rsp_rdata_o,
`ifdef RAM_ACCESS_ERR_EN
  output logic                             err_o,
`endif
  output logic                             init_done_o
);

  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int IDX_W = $clog2(DEPTH);

  ram_state_e             state, state_next;
  logic [IDX_W-1:0]       clr_cnt;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [IDX_W-1:0]       idx;
  logic                   accept;
  logic                   req_err;
  logic                   wr_commit;
  logic                   rd_accept;

  assign idx = req_addr_i[IDX_W+1:2];

`ifdef RAM_ACCESS_ERR_EN
  // Shifting out the in-range bits avoids computing DEPTH*4 in ADDR_WIDTH bits.
  assign req_err = (req_addr_i[1:0] != 2'b00) || ((req_addr_i >> (IDX_W + 2)) != '0);
`else
  logic unused_addr_bits;
  assign req_err          = 1'b0;
  assign unused_addr_bits = ^{req_addr_i[1:0], req_addr_i[ADDR_WIDTH-1:IDX_W+2]};
`endif

  assign accept    = req_valid_i && req_ready_o;
  assign wr_commit = accept && (req_we_i == WRITE_ENABLE) && !req_err;
  assign rd_accept = accept && (req_we_i != WRITE_ENABLE);

  // State register and the zero-fill counter; the counter only runs in INIT.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= RAM_ST_INIT;
      clr_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == RAM_ST_INIT) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // The edge that clears the last word hands over to READY, which is only
  // left again through reset.
  always_comb begin
    state_next  = state;
    req_ready_o = 1'b0;
    case (state)
      RAM_ST_INIT: begin
        if (clr_cnt == IDX_W'(DEPTH - 1)) state_next = RAM_ST_READY;
      end
      RAM_ST_READY: begin
        req_ready_o = 1'b1;
      end
      default: state_next = RAM_ST_INIT;
    endcase
  end

  assign init_done_o = req_ready_o;

  // Storage: zero-fill during INIT, byte-lane writes afterwards. Requests are
  // never accepted in INIT, so the two write sources cannot collide.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state == RAM_ST_INIT) begin
        mem[clr_cnt] <= '0;
      end else if (wr_commit) begin
        for (int k = 0; k < NB; k++) begin
          if (req_be_i[k]) mem[idx][k*BYTE_WIDTH +: BYTE_WIDTH] <= req_wdata_i[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  ram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk_i       (clk_i),
    .flush_i     (rst_i),
    .in_valid_i  (rd_accept),
    .in_data_i   (req_err ? '0 : mem[idx]),
`ifdef RAM_ACCESS_ERR_EN
    .in_err_i    (accept && req_err),
    .out_err_o   (err_o),
`endif
    .out_valid_o (rsp_valid_o),
    .out_data_o  (rsp_rdata_o)
  );

endmodule
